// File: rtl/qe_pkg.sv
// Shared types and helpers for the quadrature-encoder counter: decode modes,
// step classification and the forward Gray-sequence lookup.
package qe_pkg;

   localparam logic [1:0] QE_X1 = 2'd0;
   localparam logic [1:0] QE_X2 = 2'd1;
   localparam logic [1:0] QE_X4 = 2'd2;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DN   = 2'd2,
      STEP_ILL  = 2'd3
   } step_e;

   // Forward sequence on {i,q}: 00 -> 10 -> 11 -> 01 -> 00
   function automatic logic [1:0] qe_fwd_next(input logic [1:0] iq);
      logic [1:0] nxt;
      case (iq)
         2'b00:   nxt = 2'b10;
         2'b10:   nxt = 2'b11;
         2'b11:   nxt = 2'b01;
         default: nxt = 2'b00;
      endcase
      return nxt;
   endfunction

   function automatic step_e qe_classify(input logic [1:0] prev, input logic [1:0] cur);
      step_e s;
      if (prev == cur)
         s = STEP_NONE;
      else if ((prev ^ cur) == 2'b11)
         s = STEP_ILL;
      else if (qe_fwd_next(prev) == cur)
         s = STEP_UP;
      else
         s = STEP_DN;
      return s;
   endfunction

endpackage

// File: rtl/qe_sync.sv
// Multi-flop synchroniser for one asynchronous encoder pin.
module qe_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic s
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign s = sync_q[STAGES-1];

endmodule

// File: rtl/qe_counter.sv
// Quadrature-encoder position counter: pin synchronisation, x1/x2/x4 decode,
// wrapping position with carry/borrow, load, index capture and error flag.
module qe_counter
   import qe_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter bit IDX_ZERO    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i,
   input  logic             q,
   input  logic             idx,
   input  logic [1:0]       mode,
   input  logic             dir_inv,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             err_clr,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             c,
   output logic             b,
   output logic             err,
   output logic [WIDTH-1:0] idx_cap,
   output logic             idx_valid
);

   // Stay unprimed until the synchronisers and prev hold real pin data, so
   // pins already away from 00 at reset release never look like a transition.
   localparam int            PW         = $clog2(SYNC_STAGES + 2);
   localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES + 1);

   logic             i_s, q_s, idx_s;
   logic [1:0]       cur_iq;
   logic [1:0]       prev_q, prev_d;
   logic             idx_prev_q, idx_prev_d;
   logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
   logic             primed;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] idx_cap_q, idx_cap_d;
   logic             dir_q, dir_d;
   logic             c_q, c_d;
   logic             b_q, b_d;
   logic             err_q, err_d;
   logic             idx_valid_q, idx_valid_d;
   logic             counted;
   logic             idx_rise;
   step_e            raw_step;
   step_e            step;

   qe_sync #(.STAGES(SYNC_STAGES)) u_sync_i   (.clk(clk), .rst(rst), .d(i),   .s(i_s));
   qe_sync #(.STAGES(SYNC_STAGES)) u_sync_q   (.clk(clk), .rst(rst), .d(q),   .s(q_s));
   qe_sync #(.STAGES(SYNC_STAGES)) u_sync_idx (.clk(clk), .rst(rst), .d(idx), .s(idx_s));

   assign cur_iq   = {i_s, q_s};
   assign primed   = (prime_cnt_q == PRIME_LAST);
   assign idx_rise = primed & idx_s & ~idx_prev_q;

   always_comb begin
      raw_step = qe_classify(prev_q, cur_iq);
      case (mode)
         QE_X1:   counted = ((prev_q == 2'b00) && (cur_iq == 2'b10)) ||
                            ((prev_q == 2'b10) && (cur_iq == 2'b00));
         QE_X2:   counted = prev_q[1] ^ cur_iq[1];
         default: counted = 1'b1;
      endcase
      step = STEP_NONE;
      if (primed) begin
         if (raw_step == STEP_ILL)
            step = STEP_ILL;
         else if ((raw_step != STEP_NONE) && counted)
            step = ((raw_step == STEP_UP) ^ dir_inv) ? STEP_UP : STEP_DN;
      end
   end

   always_comb begin
      prev_d      = cur_iq;
      idx_prev_d  = idx_s;
      prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + PW'(1);
      count_d     = count_q;
      idx_cap_d   = idx_cap_q;
      idx_valid_d = idx_valid_q;
      dir_d       = dir_q;
      c_d         = 1'b0;
      b_d         = 1'b0;
      err_d       = (err_q & ~err_clr) | (step == STEP_ILL);

      // Load wins over the index clear, which wins over the decoded step.
      if (load) begin
         count_d     = load_val;
         idx_valid_d = 1'b0;
      end else if (IDX_ZERO && idx_rise) begin
         count_d = '0;
      end else if (step == STEP_UP) begin
         count_d = count_q + WIDTH'(1);
         c_d     = (count_q == '1);
         dir_d   = 1'b1;
      end else if (step == STEP_DN) begin
         count_d = count_q - WIDTH'(1);
         b_d     = (count_q == '0);
         dir_d   = 1'b0;
      end

      if (idx_rise) begin
         idx_cap_d   = count_q;
         idx_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q      <= 2'b00;
         idx_prev_q  <= 1'b0;
         prime_cnt_q <= '0;
         count_q     <= '0;
         idx_cap_q   <= '0;
         idx_valid_q <= 1'b0;
         dir_q       <= 1'b0;
         c_q         <= 1'b0;
         b_q         <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         idx_prev_q  <= idx_prev_d;
         prime_cnt_q <= prime_cnt_d;
         count_q     <= count_d;
         idx_cap_q   <= idx_cap_d;
         idx_valid_q <= idx_valid_d;
         dir_q       <= dir_d;
         c_q         <= c_d;
         b_q         <= b_d;
         err_q       <= err_d;
      end
   end

   assign count     = count_q;
   assign dir       = dir_q;
   assign c         = c_q;
   assign b         = b_q;
   assign err       = err_q;
   assign idx_cap   = idx_cap_q;
   assign idx_valid = idx_valid_q;

endmodule

// File: tb/tb_qe_counter.sv
// Randomised self-checking bench for qe_counter against a position model
// driven by the logical encoder phase the bench applies to the pins.
module tb_qe_counter;

   localparam int W = 16;
   localparam int S = 2;
   localparam logic [W-1:0] MAXV = '1;

   logic         clk = 1'b0;
   logic         rst;
   logic         i, q, idx;
   logic [1:0]   mode;
   logic         dir_inv, load, err_clr;
   logic [W-1:0] load_val;
   logic [W-1:0] count, idx_cap;
   logic         dir, c, b, err, idx_valid;

   qe_counter #(.WIDTH(W), .SYNC_STAGES(S), .IDX_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst), .i(i), .q(q), .idx(idx), .mode(mode),
      .dir_inv(dir_inv), .load(load), .load_val(load_val), .err_clr(err_clr),
      .count(count), .dir(dir), .c(c), .b(b), .err(err),
      .idx_cap(idx_cap), .idx_valid(idx_valid)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int txn      = 0;
   int c_pulses = 0;
   int b_pulses = 0;

   always @(posedge clk) begin
      #1;
      if (c === 1'b1) c_pulses = c_pulses + 1;
      if (b === 1'b1) b_pulses = b_pulses + 1;
   end

   // Model state: pin phase in the forward sequence plus expected outputs
   logic [1:0]   seq [4];
   int           phase;
   logic [W-1:0] m_count, m_cap;
   logic         m_dir, m_err, m_valid;
   int           m_c, m_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      repeat (S + 3) @(negedge clk);
   endtask

   task automatic check_all(input string tag);
      txn = txn + 1;
      $display("txn %0d %-8s mode=%0d inv=%0d count=%04h dir=%0d err=%0d cap=%04h valid=%0d",
               txn, tag, mode, dir_inv, count, dir, err, idx_cap, idx_valid);
      chk({tag, ".count"},   32'(count),     32'(m_count));
      chk({tag, ".dir"},     32'(dir),       32'(m_dir));
      chk({tag, ".err"},     32'(err),       32'(m_err));
      chk({tag, ".idx_cap"}, 32'(idx_cap),   32'(m_cap));
      chk({tag, ".valid"},   32'(idx_valid), 32'(m_valid));
      chk({tag, ".c"},       32'(c_pulses),  32'(m_c));
      chk({tag, ".b"},       32'(b_pulses),  32'(m_b));
   endtask

   task automatic begin_txn();
      c_pulses = 0;
      b_pulses = 0;
      m_c      = 0;
      m_b      = 0;
   endtask

   task automatic do_step(input bit fwd);
      int         np;
      logic [1:0] oldv, newv;
      bit         cnt, up;
      begin_txn();
      np   = fwd ? (phase + 1) % 4 : (phase + 3) % 4;
      oldv = seq[phase];
      newv = seq[np];
      {i, q} = newv;
      if (mode == 2'd1)
         cnt = (oldv[1] != newv[1]);
      else if (mode == 2'd0)
         cnt = (oldv == 2'b00 && newv == 2'b10) || (oldv == 2'b10 && newv == 2'b00);
      else
         cnt = 1'b1;
      if (cnt) begin
         up = fwd ^ dir_inv;
         if (up) begin
            if (m_count == MAXV) m_c = 1;
            m_count = m_count + 1'b1;
         end else begin
            if (m_count == '0) m_b = 1;
            m_count = m_count - 1'b1;
         end
         m_dir = up;
      end
      phase = np;
      settle();
      check_all(fwd ? "fwd" : "rev");
   endtask

   task automatic do_illegal();
      begin_txn();
      phase  = (phase + 2) % 4;
      {i, q} = seq[phase];
      m_err  = 1'b1;
      settle();
      check_all("illegal");
   endtask

   task automatic do_load(input logic [W-1:0] v);
      begin_txn();
      load     = 1'b1;
      load_val = v;
      @(negedge clk);
      load     = 1'b0;
      m_count  = v;
      m_valid  = 1'b0;
      settle();
      check_all("load");
   endtask

   task automatic do_err_clr();
      begin_txn();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err   = 1'b0;
      settle();
      check_all("errclr");
   endtask

   task automatic do_idx();
      begin_txn();
      idx     = 1'b1;
      m_cap   = m_count;
      m_valid = 1'b1;
      m_count = '0;
      settle();
      check_all("idx_rise");
      idx = 1'b0;
      settle();
      check_all("idx_fall");
   endtask

   // Load lands in exactly the cycle the synchronised index edge is seen
   task automatic do_idx_load(input logic [W-1:0] v);
      begin_txn();
      idx = 1'b1;
      repeat (S) @(negedge clk);
      load     = 1'b1;
      load_val = v;
      @(negedge clk);
      load    = 1'b0;
      m_cap   = m_count;
      m_valid = 1'b1;
      m_count = v;
      settle();
      idx = 1'b0;
      settle();
      check_all("idx+load");
   endtask

   task automatic do_reset(input int ph);
      begin_txn();
      phase  = ph;
      {i, q} = seq[ph];
      idx    = 1'b0;
      rst    = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.err",   32'(err),   32'd0);
      chk("rst.valid", 32'(idx_valid), 32'd0);
      rst     = 1'b0;
      m_count = '0;
      m_cap   = '0;
      m_dir   = 1'b0;
      m_err   = 1'b0;
      m_valid = 1'b0;
      c_pulses = 0;
      b_pulses = 0;
      repeat (S + 4) @(negedge clk);
      check_all("reset");
   endtask

   initial begin
      int r;
      seq[0] = 2'b00;
      seq[1] = 2'b10;
      seq[2] = 2'b11;
      seq[3] = 2'b01;
      rst = 1'b1; i = 1'b0; q = 1'b0; idx = 1'b0;
      mode = 2'd2; dir_inv = 1'b0; load = 1'b0; load_val = '0; err_clr = 1'b0;
      m_c = 0; m_b = 0;

      do_reset(0);
      for (int k = 0; k < 16; k++) do_step(1'b1);
      chk("x4_16", 32'(count), 32'd16);

      mode = 2'd1;
      do_reset(0);
      for (int k = 0; k < 16; k++) do_step(1'b1);
      chk("x2_16", 32'(count), 32'd8);

      mode = 2'd0;
      do_reset(0);
      for (int k = 0; k < 16; k++) do_step(1'b1);
      chk("x1_16", 32'(count), 32'd4);
      for (int k = 0; k < 4; k++) do_step(1'b0);
      chk("x1_rev", 32'(count), 32'd3);

      mode = 2'd2;
      do_load(16'hFFFF);
      do_step(1'b1);
      chk("carry_wrap", 32'(count), 32'h0000);
      do_step(1'b0);
      chk("borrow_wrap", 32'(count), 32'hFFFF);

      do_illegal();
      do_step(1'b1);
      do_err_clr();

      do_load(16'h0123);
      do_idx();
      chk("idx_cap_0123", 32'(idx_cap), 32'h0123);
      do_idx_load(16'h0A5A);

      do_reset(2);
      dir_inv = 1'b1;
      do_step(1'b1);
      chk("inv_fwd", 32'(count), 32'hFFFF);
      dir_inv = 1'b0;

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) dir_inv = 1'($urandom_range(0, 1));
         if (r < 60)      do_step(1'($urandom_range(0, 1)));
         else if (r < 67) do_illegal();
         else if (r < 77) do_load(W'($urandom_range(0, 65535)));
         else if (r < 84) do_err_clr();
         else if (r < 91) do_idx();
         else if (r < 95) do_idx_load(W'($urandom_range(0, 65535)));
         else             do_reset($urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
